// File: rtl/jc_bidir_n.sv
// Bidirectional WIDTH-bit Johnson counter with a step prescaler, parallel load,
// illegal-state self-correction and phase/wrap status outputs.
module jc_bidir_n #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DIV   = 1,
    parameter int unsigned PW    = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             goLeft,
    input  logic             goRight,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             dirLeft,
    output logic             run,
    output logic [PW-1:0]    phase,
    output logic             wrap,
    output logic             err
);

    localparam int unsigned   CW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned   TW     = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CntMax = CW'(DIV - 1);
    // 2*WIDTH wraps to the modulus of the phase width, which keeps 2W-pop exact.
    localparam logic [PW-1:0] TwoW   = PW'(2 * WIDTH);

    logic             runE;
    logic             dirE;
    logic             tick;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cntNext;
    logic [TW-1:0]    trans;
    logic [PW-1:0]    pop;
    logic             legal;
    logic [WIDTH-1:0] qNext;
    logic             wrapNext;
    logic             errNext;

    // Buttons are active-low; stop beats goRight beats goLeft.
    always_comb begin
        runE = run;
        dirE = dirLeft;
        if (!stop) begin
            runE = 1'b0;
        end else if (!goRight) begin
            runE = 1'b1;
            dirE = 1'b0;
        end else if (!goLeft) begin
            runE = 1'b1;
            dirE = 1'b1;
        end
    end

    always_comb begin
        tick    = 1'b0;
        cntNext = '0;
        if (runE) begin
            tick    = (cnt == CntMax);
            cntNext = tick ? '0 : cnt + 1'b1;
        end
    end

    always_comb begin
        trans = '0;
        pop   = '0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            trans = trans + TW'(q[i] ^ q[i+1]);
        end
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + PW'(q[i]);
        end
        legal = (trans <= TW'(1));
    end

    always_comb begin
        phase = '0;
        if (legal) begin
            if ((q == '0) || q[0]) begin
                phase = pop;
            end else begin
                phase = TwoW - pop;
            end
        end
    end

    always_comb begin
        qNext    = q;
        wrapNext = 1'b0;
        errNext  = 1'b0;
        if (load) begin
            qNext = d;
        end else if (!legal) begin
            qNext   = '0;
            errNext = 1'b1;
        end else if (tick) begin
            if (dirE) begin
                qNext = {q[WIDTH-2:0], ~q[WIDTH-1]};
            end else begin
                qNext = {~q[0], q[WIDTH-1:1]};
            end
            wrapNext = (qNext == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= '0;
            dirLeft <= 1'b1;
            run     <= 1'b0;
            cnt     <= '0;
            wrap    <= 1'b0;
            err     <= 1'b0;
        end else begin
            q       <= qNext;
            dirLeft <= dirE;
            run     <= runE;
            cnt     <= cntNext;
            wrap    <= wrapNext;
            err     <= errNext;
        end
    end

endmodule

// File: doc/jc_bidir_n.md
Name: jc_bidir_n

Overview:
Parametrised bidirectional Johnson counter. It generalises the 4-bit jc2 to WIDTH bits and adds a step prescaler, parallel load, illegal-state self-correction, and phase/wrap status outputs. It sits behind debounced, active-low push-button controls (goLeft/goRight/stop) and drives LED or phase-select logic.

Parameters:
WIDTH, 4, counter width in bits; must be ≥2.
DIV, 1, clock enables per shift step; must be ≥1. The counter shifts once every DIV enabled clocks.
PW, $clog2(2*WIDTH), width of the phase output. Derived; not to be overridden.

Ports:
clk  in  1  rising-edge clock; the block has one clock domain.
rst  in  1  synchronous, active-high reset.
goLeft  in  1  active-low; selects left direction and starts running.
goRight  in  1  active-low; selects right direction and starts running.
stop  in  1  active-low; halts the counter.
load  in  1  active-high; loads d into q.
d  in  WIDTH  parallel load value.
q  out  WIDTH  Johnson counter state (registered).
dirLeft  out  1  current direction; 1 = left (registered).
run  out  1  counter running (registered).
phase  out  PW  decoded position 0..2*WIDTH-1 (combinational from q).
wrap  out  1  one-cycle pulse; a shift has just returned q to all-zero (registered).
err  out  1  one-cycle pulse; an illegal q was corrected (registered).

Behaviour:
- Reset (rst=1 at an edge): q=0, dirLeft=1, run=0, prescaler cnt=0, wrap=0, err=0. Reset overrides every other input.
- Effective control, evaluated each edge in this priority:
  - stop=0: run_e=0.
  - else goRight=0: run_e=1, dir_e=right.
  - else goLeft=0: run_e=1, dir_e=left.
  - else: run_e and dir_e hold their registered values.
  - run and dirLeft register run_e and dir_e. A direction not selected keeps its old value.
- Prescaler:
  - While run_e=1: cnt increments modulo DIV; tick = (cnt==DIV-1).
  - While run_e=0: cnt is cleared to 0 and tick=0.
  - With DIV=1, tick=run_e, so the first shift happens on the same edge the button is sampled.
  - With DIV>1, the first shift happens on the DIV-th running edge.
- Legality check:
  - q is legal if the number of positions i in 0..WIDTH-2 with q[i]≠q[i+1] is ≤1.
  - There are 2*WIDTH legal states.
- q update, in priority order:
  1. load=1: q=d verbatim (no legality check). cnt is unaffected.
  2. q illegal: q=0, err=1 for one cycle, no shift.
  3. tick and dir_e=left: q = {q[WIDTH-2:0], ~q[WIDTH-1]}.
  4. tick and dir_e=right: q = {~q[0], q[WIDTH-1:1]}.
  5. Otherwise q holds.
- Shift semantics: the shift on an edge uses that edge's effective direction. Direction can therefore reverse mid-sequence with no lost step.
- wrap:
  - Set to 1 on the edge where a shift (case 3 or 4) produces q=0.
  - Cleared on the next edge.
  - Load or correction to 0 does not set wrap.
- err: 1 only for the cycle following a correction; otherwise 0.
- phase (combinational):
  - Illegal q: 0.
  - Legal q with q==0 or q[0]==1: popcount(q).
  - Otherwise: 2*WIDTH - popcount(q).
  - From q=0, left shifts give phase 0,1,...,2W-1 and then 0 again; right shifts decrement phase modulo 2W.
- Simultaneous inputs:
  - stop dominates goLeft and goRight.
  - goRight dominates goLeft.
  - load dominates shift and correction in the same edge.
  - Load while running: q takes d; shifting resumes from d on the next tick.
- Reset mid-run: q=0 and run=0 on that edge. Held-low buttons restart running on the first edge after rst is released.

Test Plan:
1. WIDTH=4, DIV=1; reset; goLeft=0 for one cycle, others high → q over successive edges: 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; phase 1..7 then 0; wrap=1 exactly one cycle after the 0000 edge; run stays 1.
2. WIDTH=4, DIV=1, from q=0000 with goRight=0 → q: 1000, 1100, 1110, 1111, 0111, ...; phase 7, 6, 5, ...; dirLeft=0.
3. Running left at q=0011; goLeft=0 and stop=0 in the same cycle → q holds 0011, run=0; later goLeft=0 and goRight=0 together → run=1, dirLeft=0, next q=0001.
4. WIDTH=4, DIV=3; goLeft pulse at edge k → first shift at edge k+2, then every 3 edges; stop then restart → cnt cleared, again 3 edges to the first shift.
5. load=1, d=0101 → q=0101; next edge q=0000, err=1 for one cycle, phase=0, wrap=0; load d=1100 → legal, no err, phase=6.
6. WIDTH=8, DIV=1, running left at q=00011111; rst=1 for one edge → q=0, run=0, wrap=0, err=0; with goLeft still low, next edge q=00000001; full 16-step cycle checked with wrap at step 16.
